// File: rtl/mc_control_fsm_pkg.sv
// Shared types and encodings for the multicycle control unit: states, opcodes,
// datapath mux codes and the bundled control-word struct.
`default_nettype none

package mc_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_WB_ALU   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_LW    = 4'h2;
  localparam logic [3:0] OP_SW    = 4'h3;
  localparam logic [3:0] OP_BEQ   = 4'h4;
  localparam logic [3:0] OP_JMP   = 4'h5;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_SEXT = 2'b10;
  localparam logic [1:0] SRCB_IMM  = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_c;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
  } ctrl_t;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_control_fsm_if.sv
// Control-unit <-> datapath bundle: status inputs to the controller and every
// mux select / write enable it drives.
`default_nettype none

interface mc_control_fsm_if #(
  parameter int OPW = 4
);
  logic [OPW-1:0] opcode;
  logic           zero;
  logic           mem_ready;
  logic           pc_write;
  logic           pc_write_c;
  logic           iord;
  logic           mem_read;
  logic           mem_write;
  logic           ir_write;
  logic           reg_dst;
  logic           mem_to_reg;
  logic           reg_write;
  logic           alu_src_a;
  logic [1:0]     alu_src_b;
  logic [1:0]     alu_op;
  logic [1:0]     pc_source;
  logic           halted;
  logic           fault;
  logic           illegal;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_c, iord, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           halted, fault, illegal
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_c, iord, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           halted, fault, illegal
  );
endinterface

`default_nettype wire

// File: rtl/mc_control_fsm_decode.sv
// Combinational output decode: current state (+opcode, memory ready) to the
// datapath control word and the illegal-opcode pulse.
`default_nettype none

module mc_control_fsm_decode
  import mc_control_fsm_pkg::*;
#(
  parameter int OPW = 4
) (
  input  state_t         state_i,
  input  logic [OPW-1:0] opcode_i,
  input  logic           mem_ready_i,
  output ctrl_t          ctrl_o,
  output logic           illegal_o
);

  logic w_legal;

  assign w_legal = (opcode_i == OPW'(OP_RTYPE)) || (opcode_i == OPW'(OP_ADDI)) ||
                   (opcode_i == OPW'(OP_LW))    || (opcode_i == OPW'(OP_SW))   ||
                   (opcode_i == OPW'(OP_BEQ))   || (opcode_i == OPW'(OP_JMP))  ||
                   (opcode_i == OPW'(OP_HALT));

  always_comb begin
    ctrl_o    = '0;
    illegal_o = 1'b0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_ONE;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        // IR and PC only load in the cycle the instruction word actually arrives
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
        illegal_o        = ~w_legal;
      end
      S_EXEC_R: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REGB;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_SEXT;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_WB_ALU: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = (opcode_i == OPW'(OP_RTYPE));
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_WB_MEM: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a  = 1'b1;
        ctrl_o.alu_src_b  = SRCB_REGB;
        ctrl_o.alu_op     = ALUOP_SUB;
        ctrl_o.pc_write_c = 1'b1;
        ctrl_o.pc_source  = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      S_HALT: ctrl_o.halted = 1'b1;
      default: ctrl_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_control_fsm.sv
// Multicycle control unit top: state register, next-state logic and the memory
// watchdog that traps a hung memory into HALT with a sticky fault.
`default_nettype none

module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int OPW      = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mc_control_fsm_if.master  bus
);

  localparam int WDW = $clog2(WAIT_MAX + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(WAIT_MAX - 1);

  state_t         state_q, state_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           fault_q, fault_d;
  ctrl_t          w_ctrl;
  logic           w_illegal;
  logic           unused_zero;

  // The zero flag gates PC_WRITE_C inside the datapath, not here
  assign unused_zero = bus.zero;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      wd_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wd_d    = '0;
    fault_d = fault_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if      (bus.opcode == OPW'(OP_RTYPE)) state_d = S_EXEC_R;
        else if (bus.opcode == OPW'(OP_ADDI))  state_d = S_EXEC_I;
        else if (bus.opcode == OPW'(OP_LW) ||
                 bus.opcode == OPW'(OP_SW))    state_d = S_MEM_ADDR;
        else if (bus.opcode == OPW'(OP_BEQ))   state_d = S_BRANCH;
        else if (bus.opcode == OPW'(OP_JMP))   state_d = S_JUMP;
        else if (bus.opcode == OPW'(OP_HALT))  state_d = S_HALT;
        else                                   state_d = S_FETCH;
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_MEM_ADDR: state_d = (bus.opcode == OPW'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (bus.mem_ready) state_d = S_WB_MEM;
      S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
      S_WB_MEM, S_WB_ALU, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_IDLE;
    endcase

    // Stall cycle number WAIT_MAX is the last one tolerated; ready on it still wins
    if (is_mem_state(state_q) && !bus.mem_ready) begin
      if (wd_q == WD_LAST) begin
        state_d = S_HALT;
        fault_d = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  mc_control_fsm_decode #(
    .OPW (OPW)
  ) u_decode (
    .state_i     (state_q),
    .opcode_i    (bus.opcode),
    .mem_ready_i (bus.mem_ready),
    .ctrl_o      (w_ctrl),
    .illegal_o   (w_illegal)
  );

  assign bus.pc_write   = w_ctrl.pc_write;
  assign bus.pc_write_c = w_ctrl.pc_write_c;
  assign bus.iord       = w_ctrl.iord;
  assign bus.mem_read   = w_ctrl.mem_read;
  assign bus.mem_write  = w_ctrl.mem_write;
  assign bus.ir_write   = w_ctrl.ir_write;
  assign bus.reg_dst    = w_ctrl.reg_dst;
  assign bus.mem_to_reg = w_ctrl.mem_to_reg;
  assign bus.reg_write  = w_ctrl.reg_write;
  assign bus.alu_src_a  = w_ctrl.alu_src_a;
  assign bus.alu_src_b  = w_ctrl.alu_src_b;
  assign bus.alu_op     = w_ctrl.alu_op;
  assign bus.pc_source  = w_ctrl.pc_source;
  assign bus.halted     = w_ctrl.halted;
  assign bus.fault      = fault_q;
  assign bus.illegal    = w_illegal;

endmodule

`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class through its
// state sequence and checks the full control word every cycle.
`default_nettype none

module tb_mc_control_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mc_control_fsm_if #(.OPW(4)) bus ();

  mc_control_fsm #(
    .OPW      (4),
    .WAIT_MAX (15)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Bit order: pcw pcwc iord mrd mwr irw rdst m2r rw srca srcb[2] op[2] pcs[2] halt fault ill
  function automatic logic [18:0] mk(input bit pcw, pcwc, iord, mr, mw, irw, rd, m2r,
                                     rw, sa, input logic [1:0] sb, op, ps,
                                     input bit h, f, il);
    return {pcw, pcwc, iord, mr, mw, irw, rd, m2r, rw, sa, sb, op, ps, h, f, il};
  endfunction

  function automatic logic [18:0] obs();
    return {bus.pc_write, bus.pc_write_c, bus.iord, bus.mem_read, bus.mem_write,
            bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.pc_source, bus.halted, bus.fault, bus.illegal};
  endfunction

  localparam logic [18:0] E_IDLE    = 19'd0;
  localparam logic [18:0] E_FETCH_W = mk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,0);
  localparam logic [18:0] E_FETCH_R = mk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,0,0);
  localparam logic [18:0] E_DECODE  = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,0);
  localparam logic [18:0] E_DEC_ILL = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,1);
  localparam logic [18:0] E_EXEC_R  = mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0,0);
  localparam logic [18:0] E_EXEC_I  = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0);
  localparam logic [18:0] E_WB_R    = mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,0,0);
  localparam logic [18:0] E_WB_I    = mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,0,0);
  localparam logic [18:0] E_MADDR   = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0);
  localparam logic [18:0] E_MRD     = mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0);
  localparam logic [18:0] E_MWR     = mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0);
  localparam logic [18:0] E_WBM     = mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,0,0);
  localparam logic [18:0] E_BR      = mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,0,0);
  localparam logic [18:0] E_JMP     = mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0,0,0);
  localparam logic [18:0] E_HALT    = mk(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1,0,0);
  localparam logic [18:0] E_HALTF   = mk(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1,1,0);

  task automatic chk(input string tag, input logic [18:0] e);
    logic [18:0] o;
    o = obs();
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%05h expected=%05h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Set inputs after the edge, let combinational outputs settle, then compare
  task automatic step(input logic [3:0] op, input logic rdy, input logic z,
                      input string tag, input logic [18:0] e);
    bus.opcode    = op;
    bus.mem_ready = rdy;
    bus.zero      = z;
    #1;
    chk(tag, e);
  endtask

  initial begin
    bus.opcode    = 4'h0;
    bus.mem_ready = 1'b0;
    bus.zero      = 1'b0;
    tick(); tick();
    chk("reset_outputs", E_IDLE);

    rst = 1'b0;
    step(4'h0, 1'b0, 1'b0, "idle_after_release", E_IDLE);
    tick(); step(4'h0, 1'b0, 1'b0, "fetch_wait", E_FETCH_W);

    // RTYPE: FETCH DECODE EXEC_R WB_ALU, then FETCH again
    step(4'h0, 1'b1, 1'b0, "r_fetch", E_FETCH_R);
    tick(); step(4'h0, 1'b1, 1'b0, "r_decode", E_DECODE);
    tick(); step(4'h0, 1'b1, 1'b0, "r_exec", E_EXEC_R);
    tick(); step(4'h0, 1'b1, 1'b0, "r_wb", E_WB_R);
    tick(); step(4'h1, 1'b1, 1'b0, "addi_fetch", E_FETCH_R);

    tick(); step(4'h1, 1'b1, 1'b0, "addi_decode", E_DECODE);
    tick(); step(4'h1, 1'b1, 1'b0, "addi_exec", E_EXEC_I);
    tick(); step(4'h1, 1'b1, 1'b0, "addi_wb", E_WB_I);
    tick(); step(4'h2, 1'b1, 1'b0, "lw_fetch", E_FETCH_R);

    // LW with three stall cycles in MEM_RD
    tick(); step(4'h2, 1'b1, 1'b0, "lw_decode", E_DECODE);
    tick(); step(4'h2, 1'b0, 1'b0, "lw_maddr", E_MADDR);
    tick(); step(4'h2, 1'b0, 1'b0, "lw_mrd_stall1", E_MRD);
    tick(); step(4'h2, 1'b0, 1'b0, "lw_mrd_stall2", E_MRD);
    tick(); step(4'h2, 1'b0, 1'b0, "lw_mrd_stall3", E_MRD);
    tick(); step(4'h2, 1'b1, 1'b0, "lw_mrd_ready", E_MRD);
    tick(); step(4'h2, 1'b1, 1'b0, "lw_wb", E_WBM);
    tick(); step(4'h3, 1'b1, 1'b0, "sw_fetch", E_FETCH_R);

    tick(); step(4'h3, 1'b1, 1'b0, "sw_decode", E_DECODE);
    tick(); step(4'h3, 1'b1, 1'b0, "sw_maddr", E_MADDR);
    tick(); step(4'h3, 1'b1, 1'b0, "sw_mwr", E_MWR);
    tick(); step(4'h4, 1'b1, 1'b1, "beq1_fetch", E_FETCH_R);

    tick(); step(4'h4, 1'b1, 1'b1, "beq1_decode", E_DECODE);
    tick(); step(4'h4, 1'b1, 1'b1, "beq1_branch", E_BR);
    tick(); step(4'h4, 1'b1, 1'b0, "beq0_fetch", E_FETCH_R);
    tick(); step(4'h4, 1'b1, 1'b0, "beq0_decode", E_DECODE);
    tick(); step(4'h4, 1'b1, 1'b0, "beq0_branch", E_BR);
    tick(); step(4'h5, 1'b1, 1'b0, "jmp_fetch", E_FETCH_R);

    tick(); step(4'h5, 1'b1, 1'b0, "jmp_decode", E_DECODE);
    tick(); step(4'h5, 1'b1, 1'b0, "jmp_jump", E_JMP);
    tick(); step(4'h7, 1'b1, 1'b0, "ill_fetch", E_FETCH_R);

    tick(); step(4'h7, 1'b1, 1'b0, "ill_decode_pulse", E_DEC_ILL);
    tick(); step(4'h7, 1'b0, 1'b0, "ill_back_to_fetch", E_FETCH_W);

    // Watchdog: the FETCH just entered is the first of 15 tolerated stalls
    for (int i = 0; i < 14; i++) begin
      tick(); step(4'h7, 1'b0, 1'b0, $sformatf("wd_stall%0d", i + 2), E_FETCH_W);
    end
    tick(); step(4'h7, 1'b0, 1'b0, "wd_halt_fault", E_HALTF);
    tick(); step(4'h0, 1'b1, 1'b0, "wd_halt_sticky", E_HALTF);

    rst = 1'b1;
    step(4'h0, 1'b1, 1'b0, "reset_clears_fault", E_IDLE);
    tick(); rst = 1'b0;
    step(4'h0, 1'b1, 1'b0, "idle_again", E_IDLE);
    tick(); step(4'h0, 1'b1, 1'b0, "fetch_before_midreset", E_FETCH_R);

    rst = 1'b1;
    step(4'h0, 1'b1, 1'b0, "midfetch_reset", E_IDLE);
    tick(); step(4'h0, 1'b1, 1'b0, "midfetch_reset_held", E_IDLE);
    rst = 1'b0;
    tick(); step(4'hF, 1'b1, 1'b0, "halt_fetch", E_FETCH_R);
    tick(); step(4'hF, 1'b1, 1'b0, "halt_decode", E_DECODE);
    tick(); step(4'hF, 1'b1, 1'b0, "halt_state", E_HALT);
    tick(); step(4'h0, 1'b1, 1'b0, "halt_stays", E_HALT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
